// File: rtl/execute_muldiv_unit_pkg.sv
// Shared definitions for the Execute-stage multiply/divide unit: op encodings,
// FSM state type and the default operand width.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/execute_muldiv_unit_if.sv
// Request/result bundle between the Execute stage and the multiply/divide unit.
interface execute_muldiv_unit_if #(
  parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH
);
  // StartE is a single-cycle request taken only while Busy=0 and CLR=0; there
  // is no ready, Busy is the back-pressure and Done marks the HI/LO write.
  logic             CLR;
  logic             StartE;
  logic [1:0]       OpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output CLR, StartE, OpE, SrcAE, SrcBE,
    input  Busy, Done, DivZero, HI, LO
  );

  modport slave (
    input  CLR, StartE, OpE, SrcAE, SrcBE,
    output Busy, Done, DivZero, HI, LO
  );
endinterface

// File: rtl/muldiv_restoring_divider.sv
// One restoring-division step: shifts the next dividend bit into the partial
// remainder and shifts one quotient bit into the dividend/quotient register.
module muldiv_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  always_comb begin
    w_shifted = {i_rem, i_quo[WIDTH-1]};
    w_trial   = w_shifted - {1'b0, i_divisor};
    // A borrow out of the top bit means the trial subtraction is undone.
    if (w_trial[WIDTH]) begin
      o_rem = w_shifted[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end else begin
      o_rem = w_trial[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the Execute stage; results land in HI/LO
// WIDTH+1 cycles after the start is accepted. Divider built only with MULDIV_DIV_EN.
module execute_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  execute_muldiv_unit_if.slave   mdu,
  output state_t                 o_dbg_state
);

  localparam int              CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   r_a;
  logic               r_neg_res;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic               w_signed_op;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_accept;
  logic               w_fin_write;

`ifdef MULDIV_DIV_EN
  logic               r_is_div;
  logic               r_neg_rem;
  logic [WIDTH-1:0]   r_b;
  logic               r_div_zero;
  logic [WIDTH-1:0]   w_div_rem;
  logic [WIDTH-1:0]   w_div_quo;

  muldiv_restoring_divider #(.WIDTH(WIDTH)) u_div (
    .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
    .i_quo     (r_acc[WIDTH-1:0]),
    .i_divisor (r_b),
    .o_rem     (w_div_rem),
    .o_quo     (w_div_quo)
  );
`endif

  // Operands are reduced to magnitudes at accept; signs are re-applied in FIN.
  assign w_signed_op = op_is_signed(mdu.OpE);
  assign w_a_neg     = w_signed_op && mdu.SrcAE[WIDTH-1];
  assign w_b_neg     = w_signed_op && mdu.SrcBE[WIDTH-1];
  assign w_a_mag     = w_a_neg ? -mdu.SrcAE : mdu.SrcAE;
  assign w_b_mag     = w_b_neg ? -mdu.SrcBE : mdu.SrcBE;

`ifdef MULDIV_DIV_EN
  assign w_accept = (r_state == IDLE) && mdu.StartE && !mdu.CLR;
`else
  assign w_accept = (r_state == IDLE) && mdu.StartE && !mdu.CLR && !mdu.OpE[1];
`endif

  assign w_fin_write = (r_state == FIN) && !mdu.CLR;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next_state = RUN;
      RUN: begin
        if (mdu.CLR)                w_next_state = IDLE;
        else if (r_cnt == LAST_ITER) w_next_state = FIN;
      end
      FIN:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Shift-add: the multiplier sits in the low half and is consumed LSB first.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    if (r_is_div) w_acc_step = {w_div_rem, w_div_quo};
`endif
  end

  always_comb begin
    w_prod   = r_neg_res ? -r_acc : r_acc;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (r_is_div) begin
      w_res_lo = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_res_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_a       <= '0;
      r_neg_res <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef MULDIV_DIV_EN
      r_is_div   <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_b        <= '0;
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_done <= w_fin_write;
`ifdef MULDIV_DIV_EN
      r_div_zero <= w_fin_write && r_is_div && (r_b == '0);
`endif
      if (w_fin_write) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
      if (w_accept) begin
        r_cnt     <= '0;
        r_a       <= w_a_mag;
        r_neg_res <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_DIV_EN
        r_is_div  <= mdu.OpE[1];
        r_neg_rem <= w_a_neg;
        r_b       <= w_b_mag;
        r_acc     <= {{WIDTH{1'b0}}, (mdu.OpE[1] ? w_a_mag : w_b_mag)};
`else
        r_acc     <= {{WIDTH{1'b0}}, w_b_mag};
`endif
      end else if (r_state == RUN) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign mdu.Busy    = (r_state != IDLE);
  assign mdu.Done    = r_done;
  assign mdu.HI      = r_hi;
  assign mdu.LO      = r_lo;
`ifdef MULDIV_DIV_EN
  assign mdu.DivZero = r_div_zero;
`else
  assign mdu.DivZero = 1'b0;
`endif
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: directed corner cases plus random
// ops scored against an arithmetic reference model.
module tb_execute_muldiv_unit;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Clock / reset
  logic   CLK = 1'b0;
  logic   RST = 1'b0;
  state_t dbg_state;
  always #5 CLK = ~CLK;

  execute_muldiv_unit_if #(.WIDTH(WIDTH)) mdu ();

  execute_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .mdu         (mdu),
    .o_dbg_state (dbg_state)
  );

  // Scoreboard: {DivZero, HI, LO}
  logic [64:0] exp_q[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, am, bm, qm, rm;
    logic [63:0] p;
    logic [31:0] hi, lo;
    logic        dz;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        p = {32'b0, a} * {32'b0, b};
        {hi, lo} = p;
      end
      2'b01: begin
        p = 64'(sa * sb);
        {hi, lo} = p;
      end
      2'b10: begin
        dz = (b == 0);
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else        begin hi = a % b; lo = a / b; end
      end
      default: begin
        dz = (b == 0);
        am = (sa < 0) ? -sa : sa;
        bm = (sb < 0) ? -sb : sb;
        if (bm == 0) begin qm = 64'h0000_0000_FFFF_FFFF; rm = am; end
        else         begin qm = am / bm; rm = am % bm; end
        lo = ((sa < 0) != (sb < 0)) ? 32'(-qm) : 32'(qm);
        hi = (sa < 0) ? 32'(-rm) : 32'(rm);
      end
    endcase
    return {dz, hi, lo};
  endfunction

  // Driver: called at a negedge; returns at the negedge where Done is seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [64:0] exp;
    int          busy_n;
    bit          seen;
    logic        busy_at_done;
    mdu.StartE = 1'b1;
    mdu.OpE    = op;
    mdu.SrcAE  = a;
    mdu.SrcBE  = b;
    @(posedge CLK);
    #1;
    mdu.StartE = 1'b0;
    if (op[1] && !DIV_EN) begin
      @(negedge CLK);
      check({tag, " ignored_busy"}, 64'(mdu.Busy), 64'(0));
      check({tag, " ignored_hilo"}, {mdu.HI, mdu.LO}, {last_hi, last_lo});
      return;
    end
    exp_q.push_back(ref_model(op, a, b));
    busy_n       = 0;
    seen         = 1'b0;
    busy_at_done = 1'b1;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge CLK);
      if (mdu.Done) begin
        seen         = 1'b1;
        busy_at_done = mdu.Busy;
      end else if (mdu.Busy) begin
        busy_n++;
      end
    end
    exp = exp_q.pop_front();
    check({tag, " done_seen"}, 64'(seen), 64'(1));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(WIDTH + 1));
    check({tag, " busy_at_done"}, 64'(busy_at_done), 64'(0));
    check({tag, " hilo"}, {mdu.HI, mdu.LO}, exp[63:0]);
    check({tag, " divzero"}, 64'(mdu.DivZero), 64'(exp[64]));
    last_hi = exp[63:32];
    last_lo = exp[31:0];
  endtask

  task automatic idle_check(input string tag);
    @(negedge CLK);
    check({tag, " pulse_end"}, {61'b0, mdu.Done, mdu.DivZero, mdu.Busy}, 64'(0));
    check({tag, " hilo_hold"}, {mdu.HI, mdu.LO}, {last_hi, last_lo});
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          sel;
    bit          saw_done, saw_busy;

    mdu.StartE = 1'b0;
    mdu.CLR    = 1'b0;
    mdu.OpE    = 2'b00;
    mdu.SrcAE  = '0;
    mdu.SrcBE  = '0;

    #2;
    check("reset_ctrl", {61'b0, mdu.Busy, mdu.Done, mdu.DivZero}, 64'(0));
    check("reset_hilo", {mdu.HI, mdu.LO}, 64'(0));
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, "multu_max");
    idle_check("multu_max");
    run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, "mult_neg");
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg_b2b");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b10, 32'h0000_000A, 32'h0000_0000, "divu_zero");
    idle_check("divu_zero");
    run_op(2'b00, 32'h8000_0001, 32'h0000_0002, "prep_clr");
    idle_check("prep_clr");

    // Abort in RUN, with an extra start pulse while busy that must be dropped.
    mdu.StartE = 1'b1;
    mdu.OpE    = 2'b00;
    mdu.SrcAE  = $urandom;
    mdu.SrcBE  = $urandom;
    @(posedge CLK);
    #1;
    mdu.StartE = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      mdu.StartE = (i == 3);
      mdu.OpE    = 2'b01;
      mdu.CLR    = (i == 10);
    end
    @(posedge CLK);
    #1;
    check("clr_busy_drop", 64'(mdu.Busy), 64'(0));
    @(negedge CLK);
    mdu.CLR  = 1'b0;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (mdu.Done) saw_done = 1'b1;
      if (mdu.Busy) saw_busy = 1'b1;
    end
    check("clr_no_done", 64'(saw_done), 64'(0));
    check("clr_no_restart", 64'(saw_busy), 64'(0));
    check("clr_hilo_kept", {mdu.HI, mdu.LO}, {32'h1, 32'h2});

    // CLR together with StartE in IDLE rejects the request.
    mdu.StartE = 1'b1;
    mdu.CLR    = 1'b1;
    @(posedge CLK);
    #1;
    mdu.StartE = 1'b0;
    mdu.CLR    = 1'b0;
    @(negedge CLK);
    check("clr_start_reject", 64'(mdu.Busy), 64'(0));

    // Asynchronous reset in the middle of an operation.
    mdu.StartE = 1'b1;
    mdu.OpE    = 2'b01;
    mdu.SrcAE  = $urandom;
    mdu.SrcBE  = $urandom;
    @(posedge CLK);
    #1;
    mdu.StartE = 1'b0;
    repeat (8) @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("rst_ctrl", {61'b0, mdu.Busy, mdu.Done, mdu.DivZero}, 64'(0));
    check("rst_hilo", {mdu.HI, mdu.LO}, 64'(0));
    last_hi = '0;
    last_lo = '0;
    @(negedge CLK);
    RST = 1'b1;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "after_rst");

    for (int k = 0; k < 16; k++) begin
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      a   = $urandom;
      b   = $urandom;
      if (sel == 1) begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
      if (sel == 2) b = '0;
      if (sel == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      run_op(op, a, b, $sformatf("rand%0d", k));
    end
    idle_check("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
